// File: rtl/mod_exp_ctrl_if.sv
// mod_exp_ctrl_if: start/stop operand bus between mod_exp_ctrl and mon_prod.
// master = exponentiation controller, slave = Montgomery multiplier.
interface mod_exp_ctrl_if #(
    parameter int bitLen     = 64,
    parameter int countWidth = 5
);
    logic                  mp_start;
    logic [bitLen-1:0]     mp_A;
    logic [bitLen-1:0]     mp_B;
    logic [bitLen-1:0]     mp_M;
    logic [countWidth-1:0] mp_num_words;
    logic                  mp_stop;
    logic [bitLen-1:0]     mp_P;

    modport master (
        output mp_start, mp_A, mp_B, mp_M, mp_num_words,
        input  mp_stop, mp_P
    );

    modport slave (
        input  mp_start, mp_A, mp_B, mp_M, mp_num_words,
        output mp_stop, mp_P
    );
endinterface

// File: rtl/mod_exp_ctrl.sv
// mod_exp_ctrl: MSB-first square-and-multiply sequencer for X^E mod M via mon_prod.
// Define SKIP_LEADING_ZEROS_EN to shift out leading zero exponent bits without ops.
module mod_exp_ctrl #(
    parameter int bitLen     = 64,
    parameter int countWidth = 5,
    parameter int expLen     = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [bitLen-1:0]     X,
    input  logic [expLen-1:0]     E,
    input  logic [bitLen-1:0]     M,
    input  logic [bitLen-1:0]     R_mod_M,
    input  logic [bitLen-1:0]     R2_mod_M,
    input  logic [countWidth-1:0] num_words,
    output logic                  busy,
    output logic                  done,
    output logic [bitLen-1:0]     P,
    mod_exp_ctrl_if.master        mp
);
    localparam int CW = $clog2(expLen) + 1;

    typedef enum logic [2:0] {
        IDLE, TOMONT, SQ, MUL, NEXT, FROMM, DONE, SKIP
    } state_t;

    state_t            state, state_nxt;
    logic [expLen-1:0] exp_q;
    logic [CW-1:0]     cnt;
    logic [bitLen-1:0] x_q, r2_q, xbar, abar;
    logic [bitLen-1:0] op_a, op_b;
    logic              op_state, issue, capture, shift;

    assign op_state = state inside {TOMONT, SQ, MUL, FROMM};
    // an op state first raises mp_start, then waits for mp_stop
    assign issue    = op_state && !mp.mp_start;
    assign capture  = op_state && mp.mp_start && mp.mp_stop;
    assign busy     = (state != IDLE) && (state != DONE);
    assign done     = (state == DONE);

    always_comb begin
        state_nxt = state;
        shift     = 1'b0;
        op_a      = abar;
        op_b      = abar;
        case (state)
            IDLE: if (start) state_nxt = TOMONT;
            TOMONT: begin
                op_a = x_q;
                op_b = r2_q;
                if (capture) begin
`ifdef SKIP_LEADING_ZEROS_EN
                    state_nxt = (exp_q == '0) ? FROMM : SKIP;
`else
                    state_nxt = (cnt == '0) ? FROMM : SQ;
`endif
                end
            end
`ifdef SKIP_LEADING_ZEROS_EN
            SKIP: begin
                if (cnt == '0)
                    state_nxt = FROMM;
                else if (exp_q[expLen-1])
                    state_nxt = SQ;
                else
                    shift = 1'b1;
            end
`endif
            SQ: begin
                if (capture) begin
                    if (exp_q[expLen-1]) begin
                        state_nxt = MUL;
                    end else begin
                        shift     = 1'b1;
                        state_nxt = NEXT;
                    end
                end
            end
            MUL: begin
                op_b = xbar;
                if (capture) begin
                    shift     = 1'b1;
                    state_nxt = NEXT;
                end
            end
            NEXT: state_nxt = (cnt == '0) ? FROMM : SQ;
            FROMM: begin
                op_b = bitLen'(1);
                if (capture) state_nxt = DONE;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exp_q           <= '0;
            cnt             <= '0;
            x_q             <= '0;
            r2_q            <= '0;
            xbar            <= '0;
            abar            <= '0;
            P               <= '0;
            mp.mp_start     <= 1'b0;
            mp.mp_A         <= '0;
            mp.mp_B         <= '0;
            mp.mp_M         <= '0;
            mp.mp_num_words <= '0;
        end else begin
            if (state == IDLE && start) begin
                x_q             <= X;
                r2_q            <= R2_mod_M;
                exp_q           <= E;
                abar            <= R_mod_M;
                cnt             <= CW'(expLen);
                mp.mp_M         <= M;
                mp.mp_num_words <= num_words;
            end
            if (issue) begin
                mp.mp_start <= 1'b1;
                mp.mp_A     <= op_a;
                mp.mp_B     <= op_b;
            end
            if (capture) begin
                mp.mp_start <= 1'b0;
                if (state == TOMONT)     xbar <= mp.mp_P;
                else if (state == FROMM) P    <= mp.mp_P;
                else                     abar <= mp.mp_P;
            end
            if (shift) begin
                exp_q <= exp_q << 1;
                cnt   <= cnt - 1'b1;
            end
        end
    end
endmodule
